// File: rtl/line_draw_arbiter_pkg.sv
// Shared types and defaults for the line rasterizer front-end arbiter.
package gpu_line_pkg;

  localparam int LINE_TIMEOUT_DEFAULT = 512;

  typedef struct packed {
    logic [7:0] x0;
    logic [7:0] y0;
    logic [7:0] x1;
    logic [7:0] y1;
  } line_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY,
    RETIRE
  } arb_state_t;

endpackage

// File: rtl/line_draw_arbiter_if.sv
// Per-requester command/completion bus between requesters and the line arbiter.
interface line_draw_arbiter_if
  import gpu_line_pkg::*;
#(
  parameter int NUM_REQ = 2
);

  logic      [NUM_REQ-1:0] req_valid;
  logic      [NUM_REQ-1:0] req_ready;
  line_cmd_t [NUM_REQ-1:0] req_cmd;
  logic      [NUM_REQ-1:0] req_done;
  logic      [NUM_REQ-1:0] req_err;

  modport master (
    output req_valid, req_cmd,
    input  req_ready, req_done, req_err
  );

  modport slave (
    input  req_valid, req_cmd,
    output req_ready, req_done, req_err
  );

endinterface

// File: rtl/line_draw_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int OWN_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWN_W-1:0]   ptr,
  output logic               gnt_valid,
  output logic [OWN_W-1:0]   gnt_idx
);

  // Walk offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i] && (((int'(ptr) + off) % NUM_REQ) == i)) begin
          gnt_valid = 1'b1;
          gnt_idx   = OWN_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/line_draw_arbiter.sv
// Shares one Bresenham rasterizer between NUM_REQ requesters with one-entry slots.
//   state  | meaning
//   IDLE   | waiting for a full slot; grant latches owner and endpoints
//   ISSUE  | rast_start pulse, timeout counter cleared
//   BUSY   | waiting for rast_done or timeout
//   RETIRE | done/err pulse to owner, slot freed, pointer advanced
module line_draw_arbiter
  import gpu_line_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = LINE_TIMEOUT_DEFAULT,
  parameter int OWN_W   = 2
) (
  input  logic                clk,
  input  logic                rst,
  line_draw_arbiter_if.slave  bus,
  output logic                rast_start,
  output logic [7:0]          rast_x0,
  output logic [7:0]          rast_y0,
  output logic [7:0]          rast_x1,
  output logic [7:0]          rast_y1,
  input  logic                rast_done,
  output logic                busy,
  output logic [OWN_W-1:0]    owner
);

  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  if ((1 << OWN_W) < NUM_REQ) begin : g_bad_own_w
    $error("OWN_W too narrow for NUM_REQ");
  end

  arb_state_t         state, state_nxt;
  logic [NUM_REQ-1:0] slot_full;
  line_cmd_t          slot_cmd [NUM_REQ];
  line_cmd_t          rast_cmd, sel_cmd;
  logic [OWN_W-1:0]   owner_q, ptr_q, gnt_idx;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q, gnt_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .OWN_W(OWN_W)) u_rr (
    .req       (slot_full),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    rast_start = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (gnt_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        rast_start = 1'b1;
        state_nxt  = BUSY;
      end
      BUSY:    if (rast_done || cnt_q == CNT_LAST) state_nxt = RETIRE;
      RETIRE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == OWN_W'(i)) sel_cmd = slot_cmd[i];
    end
  end

  always_comb begin
    bus.req_done = '0;
    bus.req_err  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (state == RETIRE && owner_q == OWN_W'(i)) begin
        bus.req_done[i] = !err_q;
        bus.req_err[i]  = err_q;
      end
    end
  end

  // Capture and retire never collide: a full slot is not ready.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst) begin
        slot_full[i] <= 1'b0;
        slot_cmd[i]  <= '0;
      end else if (bus.req_valid[i] && !slot_full[i]) begin
        slot_full[i] <= 1'b1;
        slot_cmd[i]  <= bus.req_cmd[i];
      end else if (state == RETIRE && owner_q == OWN_W'(i)) begin
        slot_full[i] <= 1'b0;
      end
    end
  end

  // err_q tracks the last BUSY cycle, so rast_done beats a same-cycle timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rast_cmd <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            owner_q  <= gnt_idx;
            rast_cmd <= sel_cmd;
          end
        end
        ISSUE: cnt_q <= '0;
        BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          err_q <= !rast_done;
        end
        RETIRE: begin
          owner_q <= '0;
          ptr_q   <= (owner_q == OWN_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = ~slot_full;
  assign owner         = owner_q;
  assign rast_x0       = rast_cmd.x0;
  assign rast_y0       = rast_cmd.y0;
  assign rast_x1       = rast_cmd.x1;
  assign rast_y1       = rast_cmd.y1;

endmodule
